bp_gshare: RTL

//  Parametrised gshare branch predictor for the fetcher/ROB pipeline.
//  The table index is the branch tag XOR a speculative global history register (GHR).

---
 rtl/bp_gshare_if.sv | 33 +++
 rtl/bp_gshare.sv | 107 ++++++++++
 2 files changed

// File: rtl/bp_gshare_if.sv
// Fetcher/ROB bundle for the gshare predictor.
//   master : fetcher + ROB side (drives requests and commits, receives predictions)
//   slave  : predictor side
// Signals:
//   in_fetcher_valid/in_fetcher_tag      prediction request
//   out_fetcher_jump/out_fetcher_ghr     prediction and history it was made with
//   in_rob_bp/jump/tag/ghr/mispredict    committing branch and its outcome
interface bp_gshare_if #(
  parameter int TAG_W = 8,
  parameter int GHR_W = 8
);
  logic             in_fetcher_valid;
  logic [TAG_W-1:0] in_fetcher_tag;
  logic             out_fetcher_jump;
  logic [GHR_W-1:0] out_fetcher_ghr;
  logic             in_rob_bp;
  logic             in_rob_jump;
  logic [TAG_W-1:0] in_rob_tag;
  logic [GHR_W-1:0] in_rob_ghr;
  logic             in_rob_mispredict;

  modport master (
    output in_fetcher_valid, in_fetcher_tag,
    output in_rob_bp, in_rob_jump, in_rob_tag, in_rob_ghr, in_rob_mispredict,
    input  out_fetcher_jump, out_fetcher_ghr
  );

  modport slave (
    input  in_fetcher_valid, in_fetcher_tag,
    input  in_rob_bp, in_rob_jump, in_rob_tag, in_rob_ghr, in_rob_mispredict,
    output out_fetcher_jump, out_fetcher_ghr
  );
endinterface

// File: rtl/bp_gshare.sv
// Gshare branch predictor: table of saturating counters indexed by
// tag ^ speculative global history. A sweep initialises the table after reset.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   rdy        global enable; all state holds when low
//   out_ready  high once the init sweep is done
//   bus        bp_gshare_if.slave (fetcher request/prediction, ROB commit)
//
// state  | meaning
// S_INIT | sweeping table to CTR_INIT, one entry per rdy cycle
// S_RUN  | predicting and training; left only by rst
module bp_gshare #(
  parameter int TAG_W    = 8,
  parameter int GHR_W    = 8,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  output logic          out_ready,
  bp_gshare_if.slave    bus
);
  localparam int DEPTH = 1 << TAG_W;
  localparam logic [CTR_W-1:0] CTR_INIT_V = CTR_W'(CTR_INIT);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_q;
  logic [TAG_W-1:0] sweep_q;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             ready_q;
  logic [CTR_W-1:0] table_q [DEPTH];

  logic             run;
  logic [TAG_W-1:0] fidx, uidx;
  logic             pred;
  logic [CTR_W-1:0] ctr_cur, ctr_d;
  logic [GHR_W-1:0] rec_hist, spec_hist;

  assign run  = (state_q == S_RUN);
  assign fidx = bus.in_fetcher_tag ^ TAG_W'(ghr_q);
  assign uidx = bus.in_rob_tag ^ TAG_W'(bus.in_rob_ghr);
  assign pred = table_q[fidx][CTR_W-1];

  assign bus.out_fetcher_jump = run & pred;
  assign bus.out_fetcher_ghr  = run ? ghr_q : '0;
  assign out_ready            = ready_q;

  assign ctr_cur = table_q[uidx];

  always_comb begin
    ctr_d = ctr_cur;
    if (bus.in_rob_jump) begin
      if (ctr_cur != {CTR_W{1'b1}}) ctr_d = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - 1'b1;
    end
  end

  // Single-bit history has nothing to shift out; it just takes the new bit.
  generate
    if (GHR_W == 1) begin : g_hist1
      assign rec_hist  = bus.in_rob_jump;
      assign spec_hist = pred;
    end else begin : g_histn
      assign rec_hist  = {bus.in_rob_ghr[GHR_W-2:0], bus.in_rob_jump};
      assign spec_hist = {ghr_q[GHR_W-2:0], pred};
    end
  endgenerate

  // Mispredict recovery wins over the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (bus.in_rob_bp && bus.in_rob_mispredict) ghr_d = rec_hist;
    else if (bus.in_fetcher_valid)              ghr_d = spec_hist;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
      ready_q <= 1'b0;
    end else if (rdy) begin
      case (state_q)
        S_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (&sweep_q) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: ghr_q <= ghr_d;
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Table storage has no reset; the sweep is what gives it defined contents.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (!run)               table_q[sweep_q] <= CTR_INIT_V;
      else if (bus.in_rob_bp) table_q[uidx]    <= ctr_d;
    end
  end
endmodule
